// File: rtl/grf_pkg.sv
// Shared defaults for the general register file and its outstanding-write scoreboard.
package grf_pkg;

  localparam int DW_DEF  = 32;
  localparam int AW_DEF  = 5;
  localparam int NR_DEF  = 2;
  localparam int CW_DEF  = 2;

  localparam int DEPTH   = 2 ** AW_DEF;
  localparam int CNT_MAX = (2 ** CW_DEF) - 1;

  localparam string TRACE_FMT = "@%h: $%d <= %h";

endpackage

// File: rtl/grf_busy_ctr.sv
// Per-register outstanding-write counter: +1 per issue, -0/1/2 per retire, clamped to 0..max.
module grf_busy_ctr
  import grf_pkg::*;
#(
  parameter int CW = CW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pause,
  input  logic          inc,
  input  logic [1:0]    dec,
  output logic [CW-1:0] count,
  output logic          underflow
);

  localparam int            MAX_I = (2 ** CW) - 1;
  localparam logic [CW+1:0] MAX_W = MAX_I[CW+1:0];

  logic [CW-1:0] count_r;
  logic [CW+1:0] sum_s;
  logic [CW+1:0] dec_s;
  logic [CW+1:0] next_s;
  logic          uf_s;

  // Net change for this cycle; a retire past zero clamps and flags underflow.
  always_comb begin
    sum_s  = {2'b00, count_r} + {{(CW+1){1'b0}}, inc};
    dec_s  = {{CW{1'b0}}, dec};
    next_s = {2'b00, count_r};
    uf_s   = 1'b0;
    if (pause) begin
      next_s = {2'b00, count_r};
    end else if (sum_s < dec_s) begin
      next_s = {(CW+2){1'b0}};
      uf_s   = 1'b1;
    end else if ((sum_s - dec_s) > MAX_W) begin
      next_s = MAX_W;
    end else begin
      next_s = sum_s - dec_s;
    end
  end

  // Count register.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_r <= {CW{1'b0}};
    end else begin
      count_r <= next_s[CW-1:0];
    end
  end

  assign count     = count_r;
  assign underflow = uf_s;

endmodule

// File: rtl/grf_scoreboard.sv
// Decode-stage register file with two write-back ports, same-cycle write bypass,
// and a per-register outstanding-write scoreboard used by hazard logic to stall.
module grf_scoreboard
  import grf_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int AW = AW_DEF,
  parameter int NR = NR_DEF,
  parameter int CW = CW_DEF
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pause,
  input  logic [NR*AW-1:0] rd_adr,
  output logic [NR*DW-1:0] rd_data,
  output logic [NR-1:0]   rd_busy,
  input  logic            iss_valid,
  input  logic [AW-1:0]   iss_dst,
  output logic            iss_ready,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] wadr,
  input  logic [2*DW-1:0] wd,
  input  logic [63:0]     wpc,
  output logic            sb_err
);

  localparam int NREG = 2 ** AW;

  logic [AW-1:0]   adr0_s, adr1_s;
  logic [DW-1:0]   wd0_s, wd1_s;
  logic [1:0]      eff_s;
  logic            iss_ready_s;
  logic            iss_fire_s;
  logic [DW-1:0]   mem_r [NREG];
  logic [CW-1:0]   cnt_s [NREG];
  logic [1:0]      dec_s [NREG];
  logic [NREG-1:1] inc_s;
  logic [NREG-1:1] uf_s;
  logic [AW-1:0]   ra_s  [NR];
  logic            sb_err_r;

  assign adr0_s = wadr[AW-1:0];
  assign adr1_s = wadr[2*AW-1:AW];
  assign wd0_s  = wd[DW-1:0];
  assign wd1_s  = wd[2*DW-1:DW];

  // A write is effective only when unpaused and not aimed at the zero register.
  assign eff_s[0] = we[0] & ~pause & (adr0_s != {AW{1'b0}});
  assign eff_s[1] = we[1] & ~pause & (adr1_s != {AW{1'b0}});

  // Full counters block issue; a same-cycle retire does not reopen the slot.
  assign iss_ready_s = ~pause & ((iss_dst == {AW{1'b0}}) | (cnt_s[iss_dst] != {CW{1'b1}}));
  assign iss_fire_s  = iss_valid & iss_ready_s;
  assign iss_ready   = iss_ready_s;

  // Per-register issue and retire strobes; a two-port collision retires twice.
  always_comb begin
    inc_s = {(NREG-1){1'b0}};
    for (int r = 0; r < NREG; r++) begin
      dec_s[r] = {1'b0, eff_s[0] & (adr0_s == AW'(r))}
               + {1'b0, eff_s[1] & (adr1_s == AW'(r))};
    end
    for (int r = 1; r < NREG; r++) begin
      inc_s[r] = iss_fire_s & (iss_dst == AW'(r));
    end
  end

  assign cnt_s[0] = {CW{1'b0}};

  for (genvar g = 1; g < NREG; g++) begin : g_ctr
    grf_busy_ctr #(.CW(CW)) u_ctr (
      .clk       (clk),
      .reset     (reset),
      .pause     (pause),
      .inc       (inc_s[g]),
      .dec       (dec_s[g]),
      .count     (cnt_s[g]),
      .underflow (uf_s[g])
    );
  end

  // Register storage; port 1 wins an address collision.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREG; r++) begin
        mem_r[r] <= {DW{1'b0}};
      end
    end else begin
      for (int r = 1; r < NREG; r++) begin
        if (eff_s[1] && (adr1_s == AW'(r))) begin
          mem_r[r] <= wd1_s;
        end else if (eff_s[0] && (adr0_s == AW'(r))) begin
          mem_r[r] <= wd0_s;
        end else begin
          mem_r[r] <= mem_r[r];
        end
      end
    end
  end

  // Read ports with bypass; busy reflects this cycle's retires already applied.
  always_comb begin
    rd_data = {(NR*DW){1'b0}};
    rd_busy = {NR{1'b0}};
    for (int i = 0; i < NR; i++) begin
      ra_s[i] = rd_adr[i*AW +: AW];
      if (ra_s[i] == {AW{1'b0}}) begin
        rd_data[i*DW +: DW] = {DW{1'b0}};
        rd_busy[i]          = 1'b0;
      end else begin
        if (eff_s[1] && (adr1_s == ra_s[i])) begin
          rd_data[i*DW +: DW] = wd1_s;
        end else if (eff_s[0] && (adr0_s == ra_s[i])) begin
          rd_data[i*DW +: DW] = wd0_s;
        end else begin
          rd_data[i*DW +: DW] = mem_r[ra_s[i]];
        end
        rd_busy[i] = {2'b00, cnt_s[ra_s[i]]} > {{CW{1'b0}}, dec_s[ra_s[i]]};
      end
    end
  end

  // Sticky scoreboard error, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_err_r <= 1'b0;
    end else if (!pause && (|uf_s)) begin
      sb_err_r <= 1'b1;
    end else begin
      sb_err_r <= sb_err_r;
    end
  end

  assign sb_err = sb_err_r;

`ifndef SYNTHESIS
  // Write trace, port 0 line first, both lines on a collision.
  always @(posedge clk) begin
    if (!reset && eff_s[0]) begin
      $display("@%h: $%d <= %h", wpc[31:0], adr0_s, wd0_s);
    end
    if (!reset && eff_s[1]) begin
      $display("@%h: $%d <= %h", wpc[63:32], adr1_s, wd1_s);
    end
  end
`endif

endmodule
